// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Brief    : Reads bursts of four-lane quads from a synchronous RAM and hands
//            each quad out over a ready/valid port. Optional lane-overflow
//            clipping is enabled by defining READER_CLIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [ADDR_W-1:0]   cmdBase,
    input  logic [5:0]          cmdQuads,
    output logic                chipSelect,
    output logic                readEnable,
    output logic [ADDR_W-1:0]   readAddr_0,
    output logic [ADDR_W-1:0]   readAddr_1,
    output logic [ADDR_W-1:0]   readAddr_2,
    output logic [ADDR_W-1:0]   readAddr_3,
    input  logic [DATA_W-1:0]   dOut_0,
    input  logic [DATA_W-1:0]   dOut_1,
    input  logic [DATA_W-1:0]   dOut_2,
    input  logic [DATA_W-1:0]   dOut_3,
    output logic                rdValid,
    input  logic                rdReady,
    output logic [4*DATA_W-1:0] rdData,
    output logic                rdLast,
    output logic                busy,
    output logic                done
);

    // One extra address bit exposes lane overflow when clipping is enabled.
`ifdef READER_CLIP_EN
    localparam int c_ACC_W = ADDR_W + 1;
`else
    localparam int c_ACC_W = ADDR_W;
`endif
    localparam logic [c_ACC_W-1:0] c_QUAD_STEP = c_ACC_W'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmdReady;
    logic                  r_rdStrobe;
    logic                  r_rdValid;
    logic                  r_rdLast;
    logic                  r_done;
    logic [4*DATA_W-1:0]   r_rdData;
    logic [ADDR_W-1:0]     r_readAddr [4];
    logic [3:0]            r_laneOvf;
    logic [c_ACC_W-1:0]    r_quadBase;
    logic [5:0]            r_quadIdx;
    logic [5:0]            r_quads;

    logic                  w_issue;
    logic [c_ACC_W-1:0]    w_issueBase;
    logic [c_ACC_W-1:0]    w_laneAddr [4];
    logic [ADDR_W-1:0]     w_laneOut  [4];
    logic [3:0]            w_laneOvf;
    logic [DATA_W-1:0]     w_dOut     [4];
    logic [4*DATA_W-1:0]   w_capData;

    assign w_dOut[0] = dOut_0;
    assign w_dOut[1] = dOut_1;
    assign w_dOut[2] = dOut_2;
    assign w_dOut[3] = dOut_3;

    // A quad is issued either straight from a fresh command or after the
    // previous non-final quad has been accepted downstream.
    assign w_issue = ((r_state == IDLE) && cmdValid && r_cmdReady && (cmdQuads != 6'd0)) ||
                     ((r_state == HOLD) && rdReady && !r_rdLast);
    assign w_issueBase = (r_state == IDLE) ? c_ACC_W'(cmdBase) : (r_quadBase + c_QUAD_STEP);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam logic [c_ACC_W-1:0] c_OFFS = c_ACC_W'(i);
        assign w_laneAddr[i] = w_issueBase + c_OFFS;
`ifdef READER_CLIP_EN
        assign w_laneOvf[i] = w_laneAddr[i][ADDR_W];
`else
        assign w_laneOvf[i] = 1'b0;
`endif
        assign w_laneOut[i] = w_laneOvf[i] ? '0 : w_laneAddr[i][ADDR_W-1:0];
        assign w_capData[i*DATA_W +: DATA_W] = r_laneOvf[i] ? '0 : w_dOut[i];
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b0;
            r_rdStrobe <= 1'b0;
            r_rdValid  <= 1'b0;
            r_rdLast   <= 1'b0;
            r_done     <= 1'b0;
            r_rdData   <= '0;
            r_laneOvf  <= '0;
            r_quadBase <= '0;
            r_quadIdx  <= '0;
            r_quads    <= '0;
            for (int i = 0; i < 4; i++) r_readAddr[i] <= '0;
        end else begin
            r_rdStrobe <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 4; i++) r_readAddr[i] <= '0;

            case (r_state)
                IDLE: begin
                    r_cmdReady <= 1'b1;
                    if (cmdValid && r_cmdReady) begin
                        if (cmdQuads != 6'd0) begin
                            r_state    <= ISSUE;
                            r_cmdReady <= 1'b0;
                            r_quads    <= cmdQuads;
                            r_quadIdx  <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_rdData  <= w_capData;
                    r_rdLast  <= (r_quadIdx == (r_quads - 6'd1)) || (|r_laneOvf);
                    r_rdValid <= 1'b1;
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (rdReady) begin
                        r_rdValid <= 1'b0;
                        r_rdLast  <= 1'b0;
                        if (r_rdLast) begin
                            r_state    <= IDLE;
                            r_done     <= 1'b1;
                            r_cmdReady <= 1'b1;
                        end else begin
                            r_state   <= ISSUE;
                            r_quadIdx <= r_quadIdx + 6'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_issue) begin
                r_rdStrobe <= 1'b1;
                r_laneOvf  <= w_laneOvf;
                r_quadBase <= w_issueBase;
                for (int i = 0; i < 4; i++) r_readAddr[i] <= w_laneOut[i];
            end
        end
    end

    assign cmdReady   = r_cmdReady;
    assign chipSelect = r_rdStrobe;
    assign readEnable = r_rdStrobe;
    assign readAddr_0 = r_readAddr[0];
    assign readAddr_1 = r_readAddr[1];
    assign readAddr_2 = r_readAddr[2];
    assign readAddr_3 = r_readAddr[3];
    assign rdValid    = r_rdValid;
    assign rdData     = r_rdData;
    assign rdLast     = r_rdLast;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM lane data width.
REQ-003 The block SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port nReset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports cmdValid input 1, cmdReady output 1: command handshake; transfer on an edge with both high.
REQ-006 The block SHALL have ports cmdBase input ADDR_W and cmdQuads input 6: burst start address and quad-read count.
REQ-007 The block SHALL have ports chipSelect output 1 and readEnable output 1: RAM read strobes.
REQ-008 The block SHALL have ports readAddr_0..readAddr_3 output ADDR_W each: four RAM read addresses.
REQ-009 The block SHALL have ports dOut_0..dOut_3 input DATA_W each: synchronous RAM read data, valid one edge after the address.
REQ-010 The block SHALL have ports rdValid output 1, rdReady input 1: output handshake.
REQ-011 The block SHALL have ports rdData output 4*DATA_W, {lane3,lane2,lane1,lane0}, and rdLast output 1: final quad of the burst.
REQ-012 The block SHALL have ports busy output 1 (state not IDLE) and done output 1 (one-cycle pulse at burst end).

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, CAPTURE, HOLD.
REQ-014 IDLE: cmdReady=1; on handshake, latch cmdBase/cmdQuads; go to ISSUE if cmdQuads!=0, else stay IDLE and pulse done next cycle with no RAM access.
REQ-015 ISSUE (exactly one cycle): chipSelect=readEnable=1, readAddr_i=base+4k+i for quad k; then go to CAPTURE.
REQ-016 CAPTURE (one cycle): strobes low; at the end of the cycle, dOut_0..3 are registered into rdData; then go to HOLD.
REQ-017 HOLD: rdValid=1; rdData and rdLast are held stable while rdReady=0; on handshake, go to ISSUE for the next quad, or to IDLE with done pulsed if that quad was the last.
REQ-018 Latency: rdValid SHALL rise on the second rising edge after the command-handshake edge; each subsequent quad takes 3 cycles when rdReady=1.
REQ-019 cmdReady SHALL be 0 in every state except IDLE; commands are never queued.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_W (wrap 0xFF->0x00) unless REQ-026 applies.
REQ-021 rdLast SHALL be 1 exactly when rdValid=1 for quad cmdQuads-1 (or the clipped final quad).
REQ-022 readAddr_i SHALL be 0 whenever readEnable=0.
REQ-023 The block SHALL never drive any RAM write signal.

Reset
REQ-024 While nReset=0: state IDLE; cmdReady, chipSelect, readEnable, rdValid, rdLast, busy, done=0; readAddr_i=0; rdData=0. cmdReady rises on the first edge after release.
REQ-025 Reset asserted mid-burst SHALL abort immediately, discard the remaining quads and produce no done pulse.

Configuration
REQ-026 With READER_CLIP_EN defined: lane addresses are computed at ADDR_W+1 bits; an overflowing lane drives readAddr 0 and has its rdData byte forced to 0; a quad containing any overflow is final (rdLast=1, done pulsed) and remaining quads are dropped. Without READER_CLIP_EN: pure wrap per REQ-020.

Verification
REQ-027 RAM preloaded addr0..4 = 00,01,10,06,12; cmd base=1, quads=1 -> readAddr 1,2,3,4; rdData=32'h12061001, rdLast=1, done one cycle after rdReady handshake.
REQ-028 base=0, quads=2, rdReady held low 5 cycles on quad 0 -> rdData=32'h06100100 stable, no readEnable during the hold; quad 1 addresses 4..7 after release.
REQ-029 base=0xFE, quads=1, no macro -> readAddr FE,FF,00,01; with READER_CLIP_EN and quads=3 -> readAddr FE,FF,00,00, bytes 2-3 = 0, rdLast=1 on first quad, single done.
REQ-030 quads=0 -> done pulse the cycle after handshake, chipSelect never asserted, rdValid stays 0.
REQ-031 nReset low during CAPTURE of quad 1 of 4 -> all outputs 0 asynchronously, no done; after release, a new cmd base=2, quads=1 returns 32'h00120610 (addr5=00).
